// File: rtl/hazard_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state codes,
// forwarding select encoding and the stage-to-select mapping.
package hazard_pipe_ctrl_pkg;

  // S_OP: IF/ID holds an opcode word. S_IMM: IF/ID holds an immediate word.
  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_e;

  // Forward select value meaning "take the operand from the register file".
  localparam logic [2:0] FWD_RF = 3'd0;

  // Scoreboard entry k (0 = EX) is reported as forward select k+1.
  function automatic logic [2:0] stage_code(input int k);
    return 3'(k + 1);
  endfunction

endpackage

// File: rtl/hazard_pipe_ctrl_scoreboard.sv
// In-flight write tracker: a DEPTH-entry shift register (entry 0 = EX,
// entry DEPTH-1 = WB) plus per-entry match vectors for the two ID operands.
module hazard_pipe_ctrl_scoreboard #(
  parameter int REG_AW = 3,
  parameter int DEPTH  = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_valid_i,
  input  logic [REG_AW-1:0] push_dst_i,
  input  logic              push_wb_i,
  input  logic              push_load_i,
  input  logic              hold0_i,
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic [REG_AW-1:0] dst_addr_i,
  output logic [DEPTH-1:0]  src_hit_o,
  output logic [DEPTH-1:0]  dst_hit_o,
  output logic              load0_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  wb_q;
  logic [REG_AW-1:0] dst_q [DEPTH];
  // The load flag only matters while the producer sits in EX, so only
  // entry 0 keeps it.
  logic              load0_q;

  // Shift toward WB every cycle; entry 0 takes the new record unless held.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      wb_q    <= '0;
      load0_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) dst_q[k] <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        wb_q[k]    <= wb_q[k-1];
        dst_q[k]   <= dst_q[k-1];
      end
      if (!hold0_i) begin
        valid_q[0] <= push_valid_i;
        wb_q[0]    <= push_wb_i;
        dst_q[0]   <= push_dst_i;
        load0_q    <= push_load_i;
      end
    end
  end

  // Per-entry match of a pending register write against each operand.
  always_comb begin
    src_hit_o = '0;
    dst_hit_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      src_hit_o[k] = valid_q[k] && wb_q[k] && (dst_q[k] == src_addr_i);
      dst_hit_o[k] = valid_q[k] && wb_q[k] && (dst_q[k] == dst_addr_i);
    end
  end

  assign load0_o = load0_q;

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// Pipeline controller for the 5-stage core: RAW hazard detection for the
// instruction in ID, stall/bubble/flush control, operand forwarding selects,
// two-word instruction sequencing and a saturating stall counter.
//
// Handshake: there is no valid/ready pair here; id_valid qualifies the ID
// opcode word, and pc_en/ifid_en act as the "ready" back to fetch -- when
// they are low the ID instruction is held and re-presented next cycle.
module hazard_pipe_ctrl
  import hazard_pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src_addr,
  input  logic              id_src_rd,
  input  logic [REG_AW-1:0] id_dst_addr,
  input  logic              id_dst_rd,
  input  logic              id_wb,
  input  logic              id_load,
  input  logic              id_two_word,
  input  logic              ex_flush,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              imm_phase,
  output logic [2:0]        fwd_src_sel,
  output logic [2:0]        fwd_dst_sel,
  output logic [CNT_W-1:0]  stall_count
);

  state_e           state_q;
  logic [CNT_W-1:0] stall_count_q;
  logic [DEPTH-1:0] src_hit, dst_hit, src_use, dst_use;
  logic             load0, check, hazard, issue, hold0;
  logic [2:0]       src_sel, dst_sel;

  // Only an opcode word in S_OP that is not being flushed is hazard-checked.
  assign check = (state_q == S_OP) && id_valid && !ex_flush;
  assign issue = check && !hazard;
  // A two-word instruction keeps its EX slot while it consumes the
  // immediate, so entry 0 is held rather than loaded with a bubble.
  assign hold0 = (state_q == S_IMM) && !ex_flush;

  hazard_pipe_ctrl_scoreboard #(
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) u_scoreboard (
    .clk_i        (clk),
    .rst_ni       (reset),
    .push_valid_i (issue),
    .push_dst_i   (id_dst_addr),
    .push_wb_i    (id_wb),
    .push_load_i  (id_load),
    .hold0_i      (hold0),
    .src_addr_i   (id_src_addr),
    .dst_addr_i   (id_dst_addr),
    .src_hit_o    (src_hit),
    .dst_hit_o    (dst_hit),
    .load0_o      (load0)
  );

  // Hazard decision: load-use only with forwarding, any match without it.
  always_comb begin
    src_use = id_src_rd ? src_hit : '0;
    dst_use = id_dst_rd ? dst_hit : '0;
    if (FWD_EN != 0) hazard = check && load0 && (src_use[0] || dst_use[0]);
    else             hazard = check && ((|src_use) || (|dst_use));
  end

  // Youngest matching stage wins: scan from WB toward EX, last hit kept.
  always_comb begin
    src_sel = FWD_RF;
    dst_sel = FWD_RF;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (src_use[k]) src_sel = stage_code(k);
      if (dst_use[k]) dst_sel = stage_code(k);
    end
  end

  // Pipeline control outputs; reset, then flush, then S_IMM, then stall.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    imm_phase   = 1'b0;
    fwd_src_sel = FWD_RF;
    fwd_dst_sel = FWD_RF;
    if (!reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (ex_flush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (state_q == S_IMM) begin
      imm_phase   = 1'b1;
      idex_bubble = 1'b1;
    end else if (hazard) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end else if (!id_valid) begin
      idex_bubble = 1'b1;
    end else if (FWD_EN != 0) begin
      fwd_src_sel = src_sel;
      fwd_dst_sel = dst_sel;
    end
  end

  // FSM and saturating stall counter, updated with the pipeline registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_OP;
      stall_count_q <= '0;
    end else begin
      if (ex_flush)                 state_q <= S_OP;
      else if (state_q == S_IMM)    state_q <= S_OP;
      else if (issue && id_two_word) state_q <= S_IMM;
      if (hazard && (stall_count_q != '1)) stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl: one forwarding instance (FWD_EN=1, 16-bit
// counter) and one stall-only instance (FWD_EN=0, 4-bit counter) share the
// same ID-stage stimulus. Directed scenarios use hand-derived constants; the
// random scenario is checked against an in-flight-producer model.
module tb_hazard_pipe_ctrl;

  localparam int DEPTH = 3;

  typedef struct packed {
    logic       v;
    logic [2:0] dst;
    logic       wb;
    logic       ld;
  } rec_t;

  typedef struct packed {
    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       imm_phase;
    logic [2:0] fs;
    logic [2:0] fd;
  } out_t;

  typedef struct packed {
    out_t o;
    logic stall;
    logic issue;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       id_valid, id_src_rd, id_dst_rd, id_wb, id_load, id_two_word, ex_flush;
  logic [2:0] id_src_addr, id_dst_addr;

  logic        f_pc_en, f_ifid_en, f_ifid_flush, f_idex_bubble, f_imm_phase;
  logic [2:0]  f_fs, f_fd;
  logic [15:0] f_cnt;
  logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_bubble, s_imm_phase;
  logic [2:0]  s_fs, s_fd;
  logic [3:0]  s_cnt;
  out_t        got_f, got_s;

  assign got_f = {f_pc_en, f_ifid_en, f_ifid_flush, f_idex_bubble, f_imm_phase, f_fs, f_fd};
  assign got_s = {s_pc_en, s_ifid_en, s_ifid_flush, s_idex_bubble, s_imm_phase, s_fs, s_fd};

  hazard_pipe_ctrl #(.REG_AW(3), .DEPTH(DEPTH), .FWD_EN(1), .CNT_W(16)) dut_f (
    .clk(clk), .reset(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_rd(id_src_rd), .id_dst_addr(id_dst_addr), .id_dst_rd(id_dst_rd),
    .id_wb(id_wb), .id_load(id_load), .id_two_word(id_two_word), .ex_flush(ex_flush),
    .pc_en(f_pc_en), .ifid_en(f_ifid_en), .ifid_flush(f_ifid_flush),
    .idex_bubble(f_idex_bubble), .imm_phase(f_imm_phase), .fwd_src_sel(f_fs),
    .fwd_dst_sel(f_fd), .stall_count(f_cnt));

  hazard_pipe_ctrl #(.REG_AW(3), .DEPTH(DEPTH), .FWD_EN(0), .CNT_W(4)) dut_s (
    .clk(clk), .reset(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_rd(id_src_rd), .id_dst_addr(id_dst_addr), .id_dst_rd(id_dst_rd),
    .id_wb(id_wb), .id_load(id_load), .id_two_word(id_two_word), .ex_flush(ex_flush),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
    .idex_bubble(s_idex_bubble), .imm_phase(s_imm_phase), .fwd_src_sel(s_fs),
    .fwd_dst_sel(s_fd), .stall_count(s_cnt));

  int total = 0;
  int bad   = 0;

  // Reference model, index 0 = forwarding core, 1 = stall-only core.
  // m_pipe[i][a] is the instruction issued a+1 cycles ago (a=0 is in EX).
  rec_t m_pipe [2][DEPTH];
  bit   m_imm  [2];
  int   m_cnt  [2];
  int   m_cmax [2] = '{65535, 15};

  // Age of the most recent in-flight producer of register r, or -1.
  function automatic int producer_age(input int i, input logic [2:0] r);
    for (int a = 0; a < DEPTH; a++)
      if (m_pipe[i][a].v && m_pipe[i][a].wb && m_pipe[i][a].dst == r) return a;
    return -1;
  endfunction

  function automatic exp_t model_eval(input int i);
    exp_t e;
    int   as, ad;
    bit   hz;
    e = '0;
    if (!rst_n) begin
      e.o.ifid_flush = 1'b1; e.o.idex_bubble = 1'b1;
      return e;
    end
    e.o.pc_en = 1'b1; e.o.ifid_en = 1'b1;
    if (ex_flush) begin
      e.o.ifid_flush = 1'b1; e.o.idex_bubble = 1'b1;
      return e;
    end
    if (m_imm[i]) begin
      e.o.imm_phase = 1'b1; e.o.idex_bubble = 1'b1;
      return e;
    end
    if (!id_valid) begin
      e.o.idex_bubble = 1'b1;
      return e;
    end
    as = id_src_rd ? producer_age(i, id_src_addr) : -1;
    ad = id_dst_rd ? producer_age(i, id_dst_addr) : -1;
    if (i == 0) hz = ((as == 0) || (ad == 0)) && m_pipe[i][0].ld;
    else        hz = (as >= 0) || (ad >= 0);
    if (hz) begin
      e.o.pc_en = 1'b0; e.o.ifid_en = 1'b0; e.o.idex_bubble = 1'b1; e.stall = 1'b1;
      return e;
    end
    e.issue = 1'b1;
    if (i == 0) begin
      e.o.fs = (as >= 0) ? 3'(as + 1) : 3'd0;
      e.o.fd = (ad >= 0) ? 3'(ad + 1) : 3'd0;
    end
    return e;
  endfunction

  // Advance one clock: model next state from pre-edge inputs, commit at edge.
  task automatic step();
    rec_t np [2][DEPTH];
    bit   ni [2];
    int   nc [2];
    exp_t e;
    rec_t nr;
    for (int i = 0; i < 2; i++) begin
      e  = model_eval(i);
      nr = '0;
      if (!rst_n) begin
        for (int a = 0; a < DEPTH; a++) np[i][a] = '0;
        ni[i] = 1'b0;
        nc[i] = 0;
      end else begin
        if (!ex_flush && m_imm[i]) nr = m_pipe[i][0];
        else if (e.issue)          nr = '{1'b1, id_dst_addr, id_wb, id_load};
        for (int a = DEPTH - 1; a > 0; a--) np[i][a] = m_pipe[i][a-1];
        np[i][0] = nr;
        ni[i] = e.issue && id_two_word;
        nc[i] = (e.stall && m_cnt[i] < m_cmax[i]) ? m_cnt[i] + 1 : m_cnt[i];
      end
    end
    @(posedge clk);
    m_pipe = np;
    m_imm  = ni;
    m_cnt  = nc;
    @(negedge clk);
  endtask

  // driver
  task automatic drive(input logic v, input logic [2:0] src, input logic src_rd,
                       input logic [2:0] dst, input logic dst_rd, input logic wb,
                       input logic ld, input logic two, input logic fl);
    id_valid = v; id_src_addr = src; id_src_rd = src_rd; id_dst_addr = dst;
    id_dst_rd = dst_rd; id_wb = wb; id_load = ld; id_two_word = two; ex_flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    drive(1, 3'd2, 1, 3'd2, 1, 1, 0, 1, 0);
    #1;
    total++; if (got_f !== 11'b00110_000_000) begin bad++; $display("FAIL reset_out_f got=%h want=%h", got_f, 11'b00110_000_000); end
    total++; if (got_s !== 11'b00110_000_000) begin bad++; $display("FAIL reset_out_s got=%h want=%h", got_s, 11'b00110_000_000); end
    step();
    step();
    total++; if (f_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt_f got=%0d want=0", f_cnt); end
    total++; if (s_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt_s got=%0d want=0", s_cnt); end
    rst_n = 1'b1;
    idle();
    #1;
    total++; if (f_pc_en !== 1'b1 || f_imm_phase !== 1'b0) begin bad++; $display("FAIL reset_release pc_en=%b imm=%b want 1/0", f_pc_en, f_imm_phase); end
    step();
  endtask

  // LDM R0,#15 then ADD R7,R0 back to back.
  task automatic test_ldm_add();
    do_reset();
    drive(1, 0, 0, 3'd0, 0, 1, 0, 1, 0);
    #1;
    total++; if (f_pc_en !== 1'b1 || f_idex_bubble !== 1'b0) begin bad++; $display("FAIL ldm_issue pc_en=%b bubble=%b want 1/0", f_pc_en, f_idex_bubble); end
    step();
    drive(1, 3'd5, 0, 3'd5, 0, 0, 0, 0, 0);
    #1;
    total++; if (f_imm_phase !== 1'b1 || f_idex_bubble !== 1'b1 || f_pc_en !== 1'b1 || f_ifid_en !== 1'b1)
      begin bad++; $display("FAIL ldm_imm imm=%b bubble=%b pc=%b ifid=%b want 1/1/1/1", f_imm_phase, f_idex_bubble, f_pc_en, f_ifid_en); end
    step();
    drive(1, 3'd0, 1, 3'd7, 1, 1, 0, 0, 0);
    #1;
    total++; if (f_pc_en !== 1'b1 || f_fs !== 3'd1 || f_fd !== 3'd0)
      begin bad++; $display("FAIL ldm_add_fwd pc=%b src=%0d dst=%0d want 1/1/0", f_pc_en, f_fs, f_fd); end
    step();
    idle();
  endtask

  // Load R1 then ADD R2,R1 held for four cycles.
  task automatic test_load_use();
    int f_st, s_st;
    bit s_fwd_seen;
    do_reset();
    f_st = 0; s_st = 0; s_fwd_seen = 0;
    drive(1, 0, 0, 3'd1, 0, 1, 1, 0, 0);
    step();
    drive(1, 3'd1, 1, 3'd2, 1, 1, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      #1;
      if (!f_pc_en) f_st++;
      if (!s_pc_en) s_st++;
      if (s_fs !== 3'd0 || s_fd !== 3'd0) s_fwd_seen = 1;
      if (c == 1) begin
        total++; if (f_fs !== 3'd2) begin bad++; $display("FAIL load_use_fwd2 got=%0d want=2", f_fs); end
      end
      step();
    end
    idle();
    total++; if (f_st != 1) begin bad++; $display("FAIL load_use_stalls_f got=%0d want=1", f_st); end
    total++; if (s_st != 3) begin bad++; $display("FAIL load_use_stalls_s got=%0d want=3", s_st); end
    total++; if (f_cnt !== 16'd1) begin bad++; $display("FAIL load_use_cnt_f got=%0d want=1", f_cnt); end
    total++; if (s_cnt !== 4'd3) begin bad++; $display("FAIL load_use_cnt_s got=%0d want=3", s_cnt); end
    total++; if (s_fwd_seen) begin bad++; $display("FAIL nofwd_sel got=1 want=0"); end
    step(); step(); step();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 0, 0, 3'd3, 0, 1, 1, 0, 0);
    step();
    drive(1, 3'd3, 1, 3'd4, 0, 1, 0, 0, 1);
    #1;
    total++; if (f_ifid_flush !== 1'b1 || f_idex_bubble !== 1'b1 || f_pc_en !== 1'b1)
      begin bad++; $display("FAIL flush_stall fl=%b bub=%b pc=%b want 1/1/1", f_ifid_flush, f_idex_bubble, f_pc_en); end
    step();
    idle();
    #1;
    total++; if (f_cnt !== 16'd0 || s_cnt !== 4'd0) begin bad++; $display("FAIL flush_cnt f=%0d s=%0d want 0/0", f_cnt, s_cnt); end
    step(); step(); step();
    drive(1, 0, 0, 3'd6, 0, 1, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    total++; if (f_ifid_flush !== 1'b1 || f_idex_bubble !== 1'b1 || f_pc_en !== 1'b1 || f_imm_phase !== 1'b0)
      begin bad++; $display("FAIL flush_imm fl=%b bub=%b pc=%b imm=%b want 1/1/1/0", f_ifid_flush, f_idex_bubble, f_pc_en, f_imm_phase); end
    step();
    idle();
    #1;
    total++; if (f_imm_phase !== 1'b0) begin bad++; $display("FAIL flush_next_op imm got=%b want=0", f_imm_phase); end
    step(); step(); step();
  endtask

  task automatic test_youngest();
    do_reset();
    drive(1, 0, 0, 3'd7, 0, 1, 0, 0, 0);
    step();
    step();
    drive(1, 3'd7, 1, 3'd7, 1, 1, 0, 0, 0);
    #1;
    total++; if (f_fs !== 3'd1 || f_fd !== 3'd1) begin bad++; $display("FAIL youngest_r7 src=%0d dst=%0d want 1/1", f_fs, f_fd); end
    idle();
    step(); step(); step(); step();
    drive(1, 0, 0, 3'd5, 0, 1, 0, 0, 0);
    step();
    step();
    idle();
    step();
    drive(1, 3'd5, 1, 3'd6, 0, 1, 0, 0, 0);
    #1;
    total++; if (f_fs !== 3'd2 || f_fd !== 3'd0) begin bad++; $display("FAIL youngest_r5 src=%0d dst=%0d want 2/0", f_fs, f_fd); end
    step();
    idle();
    step(); step(); step();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int n = 0; n < 6; n++) begin
      drive(1, 0, 0, 3'd1, 0, 1, 1, 0, 0);
      step();
      drive(1, 3'd1, 1, 3'd2, 1, 1, 0, 0, 0);
      for (int c = 0; c < 4; c++) step();
      idle();
      for (int c = 0; c < 3; c++) step();
    end
    #1;
    total++; if (s_cnt !== 4'hF) begin bad++; $display("FAIL saturate_s got=%0d want=15", s_cnt); end
    total++; if (f_cnt !== 16'd6) begin bad++; $display("FAIL saturate_f got=%0d want=6", f_cnt); end
  endtask

  task automatic test_reset_imm();
    do_reset();
    drive(1, 0, 0, 3'd0, 0, 1, 0, 1, 0);
    step();
    rst_n = 1'b0;
    idle();
    #1;
    total++; if (got_f !== 11'b00110_000_000) begin bad++; $display("FAIL reset_imm_out got=%h want=%h", got_f, 11'b00110_000_000); end
    step();
    rst_n = 1'b1;
    drive(1, 3'd0, 1, 3'd3, 0, 1, 0, 0, 0);
    #1;
    total++; if (f_pc_en !== 1'b1 || f_imm_phase !== 1'b0 || f_fs !== 3'd0)
      begin bad++; $display("FAIL reset_imm_after pc=%b imm=%b src=%0d want 1/0/0", f_pc_en, f_imm_phase, f_fs); end
    step();
    idle();
  endtask

  task automatic test_random();
    exp_t e0, e1;
    for (int n = 0; n < 500; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 11) == 0);
      #1;
      e0 = model_eval(0);
      e1 = model_eval(1);
      total++; if (got_f !== e0.o) begin bad++; $display("FAIL rand_out_f n=%0d got=%h want=%h", n, got_f, e0.o); end
      total++; if (got_s !== e1.o) begin bad++; $display("FAIL rand_out_s n=%0d got=%h want=%h", n, got_s, e1.o); end
      total++; if (f_cnt !== 16'(m_cnt[0])) begin bad++; $display("FAIL rand_cnt_f n=%0d got=%0d want=%0d", n, f_cnt, m_cnt[0]); end
      total++; if (s_cnt !== 4'(m_cnt[1])) begin bad++; $display("FAIL rand_cnt_s n=%0d got=%0d want=%0d", n, s_cnt, m_cnt[1]); end
      step();
    end
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < DEPTH; a++) m_pipe[i][a] = '0;
      m_imm[i] = 1'b0;
      m_cnt[i] = 0;
    end
    @(negedge clk);
    test_reset();
    test_ldm_add();
    test_load_use();
    test_flush();
    test_youngest();
    test_saturate();
    test_reset_imm();
    do_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
